prog_loader: RTL and testbench

Byte-stream program loader that writes instruction words into the picoMIPS program memory and holds the processor in reset until a complete, verified image is stored. It sits between a byte source (UART receiver or test bench) and the program memory write port. It is the writer side of the program memory, which the processor only reads.

---
 rtl/prog_loader_pkg.sv | 23 ++
 rtl/prog_loader_word_asm.sv | 48 ++++
 rtl/prog_loader.sv | 170 +++++++++++++++++
 tb/tb_prog_loader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared constants and state encoding for the picoMIPS program loader.
// Optional macro LOADER_CHECKSUM_EN adds the trailing checksum byte and CHK state.
package prog_loader_pkg;

    localparam logic [7:0] LOADER_SYNC = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        S_CHK   = 3'd4,
`endif
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } loader_state_t;

    function automatic int bytes_per_word(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/prog_loader_word_asm.sv
// Byte-to-word assembler: shifts bytes in MSB first and flags the last byte of a word.
// Bits above WORD_WIDTH in the first byte fall off the top of the shift.
module loader_word_asm
    import prog_loader_pkg::*;
#(
    parameter int WORD_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [7:0]            rx_byte,
    input  logic                  strobe,
    output logic [WORD_WIDTH-1:0] word,
    output logic                  word_done
);

    localparam int NB  = bytes_per_word(WORD_WIDTH);
    localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NB - 1);

    logic [BCW-1:0] byte_cnt;

    // Word-complete is flagged in the same cycle the final byte is taken.
    assign word_done = strobe && (byte_cnt == LAST_BYTE);

    // Byte position within the current word; restarts on a new frame.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            byte_cnt <= '0;
        end else if (strobe) begin
            if (byte_cnt == LAST_BYTE) begin
                byte_cnt <= '0;
            end else begin
                byte_cnt <= byte_cnt + BCW'(1);
            end
        end
    end

    // Shift register holding the word being assembled.
    always_ff @(posedge clk) begin
        if (reset) begin
            word <= '0;
        end else if (strobe) begin
            word <= WORD_WIDTH'({word, rx_byte});
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: writes framed instruction words into program
// memory and keeps the CPU in reset until a full image is stored.
// Optional macro LOADER_CHECKSUM_EN enables the trailing CHK byte.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for SYNC, other bytes dropped
// LEN     | next byte is the word count
// DATA    | collecting bytes of the current word
// WRITE   | one-cycle memory write, input stalled
// CHK     | next byte is the checksum (checksum build only)
// DONE    | image stored, CPU released; SYNC restarts
// ERROR   | load failed, CPU held; SYNC restarts
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int WORD_WIDTH = 24,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    output logic                  cpu_hold,
    output logic                  load_ok,
    output logic                  load_err
);

    localparam int CAPACITY = 2 ** ADDR_WIDTH;

    loader_state_t state, next_state;

    logic       accept;
    logic       is_sync;
    logic       len_bad;
    logic       start;
    logic       data_strobe;
    logic       word_done;
    logic       last_word;
    logic [7:0] len;
    logic [7:0] word_cnt;
    logic [8:0] word_cnt_inc;

    assign rx_ready     = !reset && (state != S_WRITE);
    assign accept       = rx_valid && rx_ready;
    assign is_sync      = (rx_data == LOADER_SYNC);
    assign len_bad      = (rx_data == 8'd0) || (int'(rx_data) > CAPACITY);
    assign data_strobe  = accept && (state == S_DATA);
    assign word_cnt_inc = {1'b0, word_cnt} + 9'd1;
    assign last_word    = (word_cnt_inc >= {1'b0, len});

    loader_word_asm #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_word_asm (
        .clk      (clk),
        .reset    (reset),
        .clear    (start),
        .rx_byte  (rx_data),
        .strobe   (data_strobe),
        .word     (mem_wdata),
        .word_done(word_done)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] checksum;

    // Running sum of LEN and data bytes; SYNC is never included.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            checksum <= 8'd0;
        end else if (accept && (state == S_LEN)) begin
            checksum <= rx_data;
        end else if (data_strobe) begin
            checksum <= checksum + rx_data;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus the write strobe and frame-start pulse.
    always_comb begin
        next_state = state;
        start      = 1'b0;
        mem_we     = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept && is_sync) begin
                    next_state = S_LEN;
                    start      = 1'b1;
                end
            end
            S_LEN: begin
                if (accept) begin
                    next_state = len_bad ? S_ERROR : S_DATA;
                end
            end
            S_DATA: begin
                if (word_done) begin
                    next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_we = !reset;
                if (!last_word) begin
                    next_state = S_DATA;
                end else begin
`ifdef LOADER_CHECKSUM_EN
                    next_state = S_CHK;
`else
                    next_state = S_DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) begin
                    next_state = (rx_data == checksum) ? S_DONE : S_ERROR;
                end
            end
`endif
            S_DONE, S_ERROR: begin
                if (accept && is_sync) begin
                    next_state = S_LEN;
                    start      = 1'b1;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Address/count tracking, latched length, and registered status flags.
    // Flags follow next_state so they change together with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr <= '0;
            word_cnt <= 8'd0;
            len      <= 8'd0;
            cpu_hold <= 1'b1;
            load_ok  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            if (start) begin
                mem_addr <= '0;
                word_cnt <= 8'd0;
            end else if (state == S_WRITE) begin
                mem_addr <= mem_addr + ADDR_WIDTH'(1);
                word_cnt <= word_cnt_inc[7:0];
            end
            if (accept && (state == S_LEN)) begin
                len <= rx_data;
            end
            cpu_hold <= (next_state != S_DONE);
            load_ok  <= (next_state == S_DONE);
            load_err <= (next_state == S_ERROR);
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: 24-bit and 20-bit instances share one byte stream.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;

    logic        rx_ready, mem_we, cpu_hold, load_ok, load_err;
    logic [5:0]  mem_addr;
    logic [23:0] mem_wdata;

    logic        rx_ready20, mem_we20, cpu_hold20, load_ok20, load_err20;
    logic [5:0]  mem_addr20;
    logic [19:0] mem_wdata20;

    int n_checks = 0;
    int n_fail   = 0;
    int last_stalls;
    int wr_count = 0;
    int last_wr_addr = -1;
    logic [23:0] mem_model [0:63];

    always #5 clk = ~clk;

    prog_loader #(.WORD_WIDTH(24), .ADDR_WIDTH(6)) u_dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .load_ok(load_ok),
        .load_err(load_err)
    );

    prog_loader #(.WORD_WIDTH(20), .ADDR_WIDTH(6)) u_dut20 (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready20), .mem_we(mem_we20), .mem_addr(mem_addr20),
        .mem_wdata(mem_wdata20), .cpu_hold(cpu_hold20), .load_ok(load_ok20),
        .load_err(load_err20)
    );

    // Record every write the 24-bit loader makes.
    always @(posedge clk) begin
        if (mem_we) begin
            mem_model[mem_addr] <= mem_wdata;
            wr_count            <= wr_count + 1;
            last_wr_addr        <= int'(mem_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one byte, wait out any stall, return 1 time unit after the accepting edge.
    task automatic send(input logic [7:0] b);
        int guard = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        last_stalls = guard;
        check("accept", {31'd0, rx_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Close a frame: CHK byte when checksums are built in, else step past the final WRITE.
    task automatic end_frame(input logic [7:0] chk);
`ifdef LOADER_CHECKSUM_EN
        send(chk);
`else
        rx_valid = 1'b0;
        if (chk == 8'h00) rx_data = 8'h00;
        @(posedge clk);
        #1;
`endif
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        logic [7:0] sum;
        logic [7:0] b0;

        reset    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("rst_load_ok", {31'd0, load_ok}, 32'd0);
        check("rst_load_err", {31'd0, load_err}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", {26'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {8'd0, mem_wdata}, 32'd0);
        rx_valid = 1'b0;
        reset    = 1'b0;
        idle(2);

        // Frame A: two words, correct checksum 05.
        send(8'hA5); send(8'h02); send(8'h12); send(8'h34);
        check("mid_word_stall", last_stalls, 0);
        send(8'h56);
        check("w0_we", {31'd0, mem_we}, 32'd1);
        check("w0_ready_low", {31'd0, rx_ready}, 32'd0);
        check("w0_addr", {26'd0, mem_addr}, 32'd0);
        check("w0_data", {8'd0, mem_wdata}, 32'h123456);
        send(8'hAB);
        check("w0_stall", last_stalls, 1);
        check("w0_addr_inc", {26'd0, mem_addr}, 32'd1);
        send(8'hCD); send(8'hEF);
        check("w1_we", {31'd0, mem_we}, 32'd1);
        check("w1_addr", {26'd0, mem_addr}, 32'd1);
        check("w1_data", {8'd0, mem_wdata}, 32'hABCDEF);
        check("a_pre_ok", {31'd0, load_ok}, 32'd0);
        end_frame(8'h05);
        check("a_load_ok", {31'd0, load_ok}, 32'd1);
        check("a_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("a_load_err", {31'd0, load_err}, 32'd0);
        check("a_writes", wr_count, 2);
        check("a_mem0", {8'd0, mem_model[0]}, 32'h123456);
        check("a_mem1", {8'd0, mem_model[1]}, 32'hABCDEF);
        idle(2);

        // Restart from DONE, then same stream with a bad checksum.
        send(8'hA5);
        check("restart_hold", {31'd0, cpu_hold}, 32'd1);
        check("restart_ok_clr", {31'd0, load_ok}, 32'd0);
        send(8'h02); send(8'h12); send(8'h34); send(8'h56);
        send(8'hAB); send(8'hCD); send(8'hEF);
        end_frame(8'h06);
`ifdef LOADER_CHECKSUM_EN
        check("b_load_err", {31'd0, load_err}, 32'd1);
        check("b_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("b_load_ok", {31'd0, load_ok}, 32'd0);
`else
        check("b_load_ok", {31'd0, load_ok}, 32'd1);
        check("b_cpu_hold", {31'd0, cpu_hold}, 32'd0);
`endif
        check("b_writes", wr_count, 4);
        idle(2);

        // Junk bytes, then LEN=0 rejected; then a one-word load.
        send(8'h00); send(8'hFF); send(8'hA5); send(8'h00);
        check("len0_err", {31'd0, load_err}, 32'd1);
        check("len0_hold", {31'd0, cpu_hold}, 32'd1);
        check("len0_ok", {31'd0, load_ok}, 32'd0);
        send(8'hA5);
        check("err_restart_clr", {31'd0, load_err}, 32'd0);
        send(8'h01); send(8'h00); send(8'h00); send(8'h07);
        end_frame(8'h08);
        check("c_mem0", {8'd0, mem_model[0]}, 32'h000007);
        check("c_load_ok", {31'd0, load_ok}, 32'd1);
        check("c_writes", wr_count, 5);
        idle(1);

        // SYNC value inside data is plain data.
        send(8'hA5); send(8'h01); send(8'hA5); send(8'h00); send(8'h01);
        end_frame(8'hA7);
        check("syncdata_mem0", {8'd0, mem_model[0]}, 32'hA50001);
        check("syncdata_ok", {31'd0, load_ok}, 32'd1);
        idle(1);

        // LEN=65 exceeds capacity.
        send(8'hA5); send(8'h41);
        check("len65_err", {31'd0, load_err}, 32'd1);
        check("len65_hold", {31'd0, cpu_hold}, 32'd1);

        // LEN=64 fills memory exactly.
        base = wr_count;
        sum  = 8'h40;
        send(8'hA5); send(8'h40);
        for (int i = 0; i < 64; i++) begin
            b0 = 8'(i);
            send(b0); send(8'h5A); send(~b0);
            sum = sum + b0 + 8'h5A + ~b0;
        end
        end_frame(sum);
        check("full_writes", wr_count - base, 64);
        check("full_last_addr", last_wr_addr, 63);
        check("full_mem63", {8'd0, mem_model[63]}, 32'h3F5AC0);
        check("full_mem0", {8'd0, mem_model[0]}, 32'h005AFF);
        check("full_addr_wrap", {26'd0, mem_addr}, 32'd0);
        check("full_load_ok", {31'd0, load_ok}, 32'd1);
        idle(1);

        // Reset after four data bytes aborts the load.
        send(8'hA5); send(8'h02); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        base = wr_count;
        rx_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check("midrst_ready", {31'd0, rx_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("midrst_hold", {31'd0, cpu_hold}, 32'd1);
        check("midrst_addr", {26'd0, mem_addr}, 32'd0);
        check("midrst_ok", {31'd0, load_ok}, 32'd0);
        reset = 1'b0;
        idle(4);
        check("midrst_no_wr", wr_count - base, 0);
        check("midrst_mem0", {8'd0, mem_model[0]}, 32'h112233);
        send(8'hA5); send(8'h01); send(8'h0A); send(8'h0B); send(8'h0C);
        check("fresh_addr", {26'd0, mem_addr}, 32'd0);
        end_frame(8'h22);
        check("fresh_mem0", {8'd0, mem_model[0]}, 32'h0A0B0C);
        check("fresh_last_addr", last_wr_addr, 0);
        check("fresh_ok", {31'd0, load_ok}, 32'd1);
        idle(1);

        // 20-bit word: upper nibble of the first byte is dropped.
        send(8'hA5); send(8'h01); send(8'hF1); send(8'h22); send(8'h33);
        check("w20_we", {31'd0, mem_we20}, 32'd1);
        check("w20_data", {12'd0, mem_wdata20}, 32'h12233);
        check("w24_data", {8'd0, mem_wdata}, 32'hF12233);
        end_frame(8'h47);
        check("w20_ok", {31'd0, load_ok20}, 32'd1);
        check("w20_hold", {31'd0, cpu_hold20}, 32'd0);
        check("w20_err", {31'd0, load_err20}, 32'd0);
        check("w20_addr", {26'd0, mem_addr20}, 32'd1);
        check("w20_ready", {31'd0, rx_ready20}, 32'd1);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
